uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Upstream loader for the multi-core processor memories.
- Consumes the received byte stream from the UART receiver and writes the program into instruction memory, then the input matrices into data memory.
- When loading is complete it asserts done, and the top-level controller moves on to processor execution.
- Data words wider than a byte are assembled from consecutive bytes, least significant byte first.

Parameters:
- INS_WIDTH, 8: instruction word width (one byte per instruction).
- INS_MEM_DEPTH, 256: instruction memory depth; address width is $clog2(INS_MEM_DEPTH).
- DATA_MEM_WIDTH, 12: data memory word width (CORE_COUNT*REG_WIDTH at top level).
- DATA_MEM_DEPTH, 4096: data memory depth; address width is $clog2(DATA_MEM_DEPTH).
- INS_LOAD_COUNT, 256: number of instruction bytes to load, range 1..INS_MEM_DEPTH.
- DATA_LOAD_COUNT, 4096: number of data words to load, range 1..DATA_MEM_DEPTH.
- Derived: BPW = (DATA_MEM_WIDTH+7)/8, the number of bytes per data word.

Ports:
- clk, input, 1: clock.
- rstN, input, 1: synchronous active-low reset.
- startN, input, 1: active-low start request, sampled in IDLE and DONE.
- rx_valid, input, 1: one-cycle strobe; rx_byte is valid in that cycle.
- rx_byte, input, 8: received byte.
- insMemWrEn, output, 1: instruction memory write strobe.
- insMemAddr, output, $clog2(INS_MEM_DEPTH): instruction memory write address.
- insMemDataOut, output, INS_WIDTH: instruction memory write data.
- dataMemWrEn, output, 1: data memory write strobe.
- dataMemAddr, output, $clog2(DATA_MEM_DEPTH): data memory write address.
- dataMemDataOut, output, DATA_MEM_WIDTH: data memory write data.
- busy, output, 1: high in LOAD_INS and LOAD_DATA.
- done, output, 1: high in DONE.

Behaviour:
- Reset (rstN low at posedge clk): state IDLE; all outputs 0; byte counter, word counter and assembly register cleared.
- Reset in the middle of a load aborts it. No partial-word write is issued.
- State machine:
  - IDLE: startN low -> LOAD_INS.
  - LOAD_INS -> LOAD_DATA when byte INS_LOAD_COUNT-1 is accepted.
  - LOAD_DATA -> DONE when the last byte of word DATA_LOAD_COUNT-1 is accepted.
  - DONE: startN low -> LOAD_INS, which restarts from address 0 with all counters cleared.
  - startN is ignored in LOAD_INS and LOAD_DATA.
- rx_valid in IDLE or DONE is ignored: no write, no counter change.
- LOAD_INS, for each rx_valid:
  - The next cycle has insMemWrEn=1 for exactly one cycle, with insMemAddr = ins count and insMemDataOut = rx_byte.
  - The ins count then increments.
- LOAD_DATA:
  - Byte k of the current word (k = 0..BPW-1) is placed at assembly bits [8k+7:8k]; bits at or above DATA_MEM_WIDTH are discarded.
  - On byte BPW-1, the next cycle has dataMemWrEn=1 for one cycle, dataMemAddr = word count, and dataMemDataOut = the full assembled word including that byte.
  - The word count then increments and the byte index returns to 0.
- Latency: every write strobe occurs exactly 1 cycle after the accepting rx_valid. Write strobes are registered outputs.
- busy and done are registered and change in the cycle after the accepting event. The final data write strobe and done rise in the same cycle.
- Back-to-back rx_valid on consecutive cycles is supported with no loss.
- The first LOAD_DATA byte may arrive in the cycle immediately after the last instruction byte.
- Addresses and data outputs hold their last values while write strobes are low; only the strobes are checked.
- Counters never wrap. The transition fires at the configured count, so an address of INS_LOAD_COUNT or DATA_LOAD_COUNT is never emitted.

Test Plan (INS_LOAD_COUNT=4, DATA_LOAD_COUNT=2, DATA_MEM_WIDTH=12, BPW=2):
- Reset, then rx_valid with 0xAA while in IDLE -> no write strobes; busy=0, done=0.
- startN pulse, then bytes 0x11,0x22,0x33,0x44 -> four insMemWrEn pulses, each 1 cycle after its rx_valid, at addresses 0..3 with those data values; state becomes LOAD_DATA.
- Data bytes 0xBC,0xFA,0x34,0x12 sent back-to-back -> dataMemWrEn pulses at addr 0 with 0xABC and addr 1 with 0x234; done=1 and busy=0 in the same cycle as the second pulse.
- In DONE, extra rx_valid 0x55 -> no write. startN pulse -> busy=1, and the next instruction byte is written at address 0.
- rstN low after one data byte (0xBC) -> no dataMemWrEn, state IDLE, outputs 0. A full reload then writes word 0 = 0xABC with no residue from the aborted byte.
- startN held low during LOAD_INS -> no restart; counts continue 0..3.

Source files
------------

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: byte-stream input and memory write ports of the program/data loader.
interface uart_mem_loader_if #(
  parameter int INS_WIDTH      = 8,
  parameter int INS_ADDR_W     = 8,
  parameter int DATA_MEM_WIDTH = 12,
  parameter int DATA_ADDR_W    = 12
);
  logic                      startN;
  logic                      rx_valid;
  logic [7:0]                rx_byte;
  logic                      insMemWrEn;
  logic [INS_ADDR_W-1:0]     insMemAddr;
  logic [INS_WIDTH-1:0]      insMemDataOut;
  logic                      dataMemWrEn;
  logic [DATA_ADDR_W-1:0]    dataMemAddr;
  logic [DATA_MEM_WIDTH-1:0] dataMemDataOut;
  logic                      busy;
  logic                      done;
  modport slave (
    input  startN, rx_valid, rx_byte,
    output insMemWrEn, insMemAddr, insMemDataOut,
    output dataMemWrEn, dataMemAddr, dataMemDataOut, busy, done
  );
  modport master (
    output startN, rx_valid, rx_byte,
    input  insMemWrEn, insMemAddr, insMemDataOut,
    input  dataMemWrEn, dataMemAddr, dataMemDataOut, busy, done
  );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: writes received UART bytes into instruction memory, then
// assembles LSB-first data words into data memory, and reports done.
module uart_mem_loader #(
  parameter int INS_WIDTH       = 8,
  parameter int INS_MEM_DEPTH   = 256,
  parameter int DATA_MEM_WIDTH  = 12,
  parameter int DATA_MEM_DEPTH  = 4096,
  parameter int INS_LOAD_COUNT  = 256,
  parameter int DATA_LOAD_COUNT = 4096
) (
  input logic clk,
  input logic rstN,
  uart_mem_loader_if.slave bus
);
  localparam int IAW = $clog2(INS_MEM_DEPTH);
  localparam int DAW = $clog2(DATA_MEM_DEPTH);
  localparam int BPW = (DATA_MEM_WIDTH + 7) / 8;
  localparam int BIW = BPW > 1 ? $clog2(BPW) : 1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_INS  = 2'd1;
  localparam logic [1:0] LOAD_DATA = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;
  logic [1:0]                state_q, state_d;
  logic [IAW-1:0]            ins_cnt_q, ins_cnt_d;
  logic [DAW-1:0]            word_cnt_q, word_cnt_d;
  logic [BIW-1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_MEM_WIDTH-1:0] asm_q, asm_d, asm_new;
  logic                      ins_we_q, ins_we_d;
  logic [IAW-1:0]            ins_addr_q, ins_addr_d;
  logic [INS_WIDTH-1:0]      ins_data_q, ins_data_d;
  logic                      data_we_q, data_we_d;
  logic [DAW-1:0]            data_addr_q, data_addr_d;
  logic [DATA_MEM_WIDTH-1:0] data_data_q, data_data_d;
  logic                      busy_q, done_q;
  always_comb begin
    state_d     = state_q;
    ins_cnt_d   = ins_cnt_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    ins_we_d    = 1'b0;
    ins_addr_d  = ins_addr_q;
    ins_data_d  = ins_data_q;
    data_we_d   = 1'b0;
    data_addr_d = data_addr_q;
    data_data_d = data_data_q;
    asm_new     = asm_q;
    // Bits of the incoming byte beyond the word width simply have no home.
    for (int b = 0; b < DATA_MEM_WIDTH; b++)
      if (b / 8 == int'(byte_idx_q)) asm_new[b] = bus.rx_byte[b % 8];
    case (state_q)
      IDLE, DONE: if (!bus.startN) begin
        state_d    = LOAD_INS;
        ins_cnt_d  = '0;
        word_cnt_d = '0;
        byte_idx_d = '0;
        asm_d      = '0;
      end
      LOAD_INS: if (bus.rx_valid) begin
        ins_we_d   = 1'b1;
        ins_addr_d = ins_cnt_q;
        ins_data_d = INS_WIDTH'(bus.rx_byte);
        ins_cnt_d  = ins_cnt_q + 1'b1;
        if (ins_cnt_q == IAW'(INS_LOAD_COUNT - 1)) state_d = LOAD_DATA;
      end
      LOAD_DATA: if (bus.rx_valid) begin
        if (byte_idx_q == BIW'(BPW - 1)) begin
          data_we_d   = 1'b1;
          data_addr_d = word_cnt_q;
          data_data_d = asm_new;
          word_cnt_d  = word_cnt_q + 1'b1;
          byte_idx_d  = '0;
          asm_d       = '0;
          if (word_cnt_q == DAW'(DATA_LOAD_COUNT - 1)) state_d = DONE;
        end else begin
          asm_d      = asm_new;
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      ins_cnt_q   <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      ins_we_q    <= 1'b0;
      ins_addr_q  <= '0;
      ins_data_q  <= '0;
      data_we_q   <= 1'b0;
      data_addr_q <= '0;
      data_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_cnt_q   <= ins_cnt_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      ins_we_q    <= ins_we_d;
      ins_addr_q  <= ins_addr_d;
      ins_data_q  <= ins_data_d;
      data_we_q   <= data_we_d;
      data_addr_q <= data_addr_d;
      data_data_q <= data_data_d;
      busy_q      <= state_d == LOAD_INS || state_d == LOAD_DATA;
      done_q      <= state_d == DONE;
    end
  end
  assign bus.insMemWrEn     = ins_we_q;
  assign bus.insMemAddr     = ins_addr_q;
  assign bus.insMemDataOut  = ins_data_q;
  assign bus.dataMemWrEn    = data_we_q;
  assign bus.dataMemAddr    = data_addr_q;
  assign bus.dataMemDataOut = data_data_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed plus random byte streams checked against a
// stream-position model of where each byte must land in memory.
module tb_uart_mem_loader;
  localparam int ICNT = 4, DCNT = 2, DW = 12, BPW = 2, IAW = 8, DAW = 12;
  localparam int TOTAL = ICNT + DCNT * BPW;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;
  uart_mem_loader_if #(.INS_WIDTH(8), .INS_ADDR_W(IAW), .DATA_MEM_WIDTH(DW), .DATA_ADDR_W(DAW)) bus ();
  uart_mem_loader #(
    .INS_WIDTH(8), .INS_MEM_DEPTH(256), .DATA_MEM_WIDTH(DW), .DATA_MEM_DEPTH(4096),
    .INS_LOAD_COUNT(ICNT), .DATA_LOAD_COUNT(DCNT)
  ) dut (.clk(clk), .rstN(rstN), .bus(bus));
  int total = 0, bad = 0;
  bit m_run, m_done;
  int m_cnt;
  int bytes [TOTAL];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.startN   = 1'b1;
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    m_run = 0; m_done = 0; m_cnt = 0;
    chk("rst_ins_we", 32'(bus.insMemWrEn), 0);
    chk("rst_ins_addr", 32'(bus.insMemAddr), 0);
    chk("rst_ins_data", 32'(bus.insMemDataOut), 0);
    chk("rst_data_we", 32'(bus.dataMemWrEn), 0);
    chk("rst_data_addr", 32'(bus.dataMemAddr), 0);
    chk("rst_data_data", 32'(bus.dataMemDataOut), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
  endtask
  // One clock of stimulus; outputs are checked at the following falling edge.
  task automatic step(input bit v, input logic [7:0] b, input bit s);
    bit ei = 0, ed = 0;
    int ia = 0, id = 0, da = 0, dd = 0, j;
    bus.rx_valid = v;
    bus.rx_byte  = b;
    bus.startN   = s;
    @(negedge clk);
    if (!m_run) begin
      if (!s) begin m_run = 1; m_done = 0; m_cnt = 0; end
    end else if (v) begin
      bytes[m_cnt] = int'(b);
      if (m_cnt < ICNT) begin
        ei = 1; ia = m_cnt; id = int'(b);
      end else begin
        j = m_cnt - ICNT;
        if (j % BPW == BPW - 1) begin
          ed = 1; da = j / BPW;
          for (int i = 0; i < BPW; i++) dd += bytes[ICNT + j - (BPW - 1) + i] << (8 * i);
          dd = dd % (1 << DW);
        end
      end
      m_cnt++;
      if (m_cnt == TOTAL) begin m_run = 0; m_done = 1; end
    end
    chk("ins_we", 32'(bus.insMemWrEn), 32'(ei));
    chk("data_we", 32'(bus.dataMemWrEn), 32'(ed));
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    if (ei) begin
      chk("ins_addr", 32'(bus.insMemAddr), ia);
      chk("ins_data", 32'(bus.insMemDataOut), id);
    end
    if (ed) begin
      chk("data_addr", 32'(bus.dataMemAddr), da);
      chk("data_word", 32'(bus.dataMemDataOut), dd);
    end
  endtask
  initial begin
    logic [7:0] ins [4];
    logic [7:0] dat [4];
    ins = '{8'h11, 8'h22, 8'h33, 8'h44};
    dat = '{8'hBC, 8'hFA, 8'h34, 8'h12};
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.startN = 1'b1; rstN = 1'b0;
    @(negedge clk);
    do_reset();
    step(1, 8'hAA, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1, ins[i], 1);
    for (int i = 0; i < 4; i++) step(1, dat[i], 1);
    chk("word1_const", 32'(bus.dataMemDataOut), 32'h234);
    step(0, 8'h00, 1);
    step(1, 8'h55, 1);
    step(0, 8'h00, 0);
    step(1, 8'h66, 1);
    for (int i = 1; i < 4; i++) step(1, ins[i], 1);
    step(1, 8'hBC, 1);
    do_reset();
    step(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1, ins[i], 1);
    step(1, 8'hBC, 1);
    step(1, 8'hFA, 1);
    chk("word0_const", 32'(bus.dataMemDataOut), 32'hABC);
    do_reset();
    step(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0);
      step(1, ins[i], 0);
    end
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      for (int n = 0; n < 30; n++)
        step(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 4) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
